fpu_cpu_bridge: RTL and testbench

FPU_CPU_BRIDGE -- requirements
Module: fpu_cpu_bridge

---
 rtl/fpu_cpu_bridge.sv | 160 ++++++++++++++++
 tb/tb_fpu_cpu_bridge.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_cpu_bridge.sv
// CPU register window onto an FPU core: operand/command/status/result bytes.
// Optional watchdog on long-running operations enabled by FPU_BRIDGE_TIMEOUT_EN.
module fpu_cpu_bridge #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_cs,
    input  logic        cpu_wr,
    input  logic        cpu_rd,
    input  logic [3:0]  cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_irq,
    output logic        fpu_start,
    output logic [3:0]  fpu_op,
    output logic [31:0] fpu_a,
    output logic [31:0] fpu_b,
    input  logic [31:0] fpu_result,
    input  logic        fpu_done,
    output logic        fpu_ack
);

    typedef enum logic [1:0] {
        br_idle_st,
        br_start_st,
        br_wait_st,
        br_ack_st
    } state_t;

    state_t state, state_nx;

    logic [31:0] opa, opb, res;
    logic [3:0]  op;
    logic        done_q, err_q, tout;
    logic        wr_en, rd_en, busy, fin, tmo_hit, busy_clr, locked;
    logic        op_wr, cmd_wr, cmd_ok, err_set, stat_clr, cap, running;
    logic [7:0]  rd_mux;

    assign wr_en    = cpu_cs & cpu_wr;
    assign rd_en    = cpu_cs & cpu_rd;
    assign busy     = (state != br_idle_st);
    assign running  = (state == br_wait_st) || (state == br_ack_st);
    assign fin      = (state == br_ack_st) && !fpu_done;
    assign busy_clr = fin | tmo_hit;
    // The cycle busy drops is already open for new writes.
    assign locked   = busy & ~busy_clr;
    assign op_wr    = wr_en && (cpu_addr <= 4'h8);
    assign cmd_wr   = wr_en && (cpu_addr == 4'h8) && !locked;
    assign cmd_ok   = cmd_wr && (cpu_wdata[3:0] <= 4'hA);
    assign err_set  = (op_wr && locked) || (cmd_wr && !cmd_ok);
    assign stat_clr = rd_en && (cpu_addr == 4'h9);
    assign cap      = (state == br_wait_st) && fpu_done && !tmo_hit;

    assign fpu_start = (state == br_start_st);
    assign fpu_ack   = (state == br_ack_st);
    assign fpu_a     = opa;
    assign fpu_b     = opb;
    assign fpu_op    = op;

`ifdef FPU_BRIDGE_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt;
    logic          tout_q;

    assign tmo_hit = running && (cnt == CW'(TIMEOUT_CYCLES - 1));
    assign tout    = tout_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt    <= '0;
            tout_q <= 1'b0;
        end else begin
            tout_q <= (tout_q & ~stat_clr) | tmo_hit;
            if (running && !busy_clr)
                cnt <= cnt + 1'b1;
            else
                cnt <= '0;
        end
    end
`else
    logic unused_timeout;

    // Parameter stays on the interface so both builds share one port map.
    assign unused_timeout = |TIMEOUT_CYCLES;
    assign tmo_hit        = 1'b0;
    assign tout           = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        unique case (state)
            br_idle_st: begin
                if (cmd_ok)
                    state_nx = br_start_st;
            end
            br_start_st: begin
                state_nx = br_wait_st;
            end
            br_wait_st: begin
                if (tmo_hit)
                    state_nx = cmd_ok ? br_start_st : br_idle_st;
                else if (fpu_done)
                    state_nx = br_ack_st;
            end
            br_ack_st: begin
                if (busy_clr)
                    state_nx = cmd_ok ? br_start_st : br_idle_st;
            end
            default: state_nx = br_idle_st;
        endcase
    end

    always_comb begin
        rd_mux = 8'h00;
        case (cpu_addr[3:2])
            2'b00: rd_mux = opa[{cpu_addr[1:0], 3'b000} +: 8];
            2'b01: rd_mux = opb[{cpu_addr[1:0], 3'b000} +: 8];
            2'b11: rd_mux = res[{cpu_addr[1:0], 3'b000} +: 8];
            default: begin
                if (cpu_addr == 4'h8)
                    rd_mux = {4'h0, op};
                else if (cpu_addr == 4'h9)
                    rd_mux = {4'h0, err_q, tout, done_q, busy};
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= br_idle_st;
            opa       <= '0;
            opb       <= '0;
            op        <= '0;
            res       <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            cpu_irq   <= 1'b0;
            cpu_rdata <= '0;
        end else begin
            state <= state_nx;
            if (wr_en && !locked && cpu_addr[3:2] == 2'b00)
                opa[{cpu_addr[1:0], 3'b000} +: 8] <= cpu_wdata;
            if (wr_en && !locked && cpu_addr[3:2] == 2'b01)
                opb[{cpu_addr[1:0], 3'b000} +: 8] <= cpu_wdata;
            if (cmd_ok)
                op <= cpu_wdata[3:0];
            if (cap)
                res <= fpu_result;
            // Sets are ORed in after the clear so a same-cycle set wins.
            done_q  <= (done_q & ~stat_clr) | fin;
            err_q   <= (err_q & ~stat_clr) | err_set;
            cpu_irq <= busy_clr;
            if (rd_en)
                cpu_rdata <= rd_mux;
        end
    end

endmodule

// File: tb/tb_fpu_cpu_bridge.sv
// Scoreboard bench for fpu_cpu_bridge: register reads checked by a monitor,
// with a simple FPU responder model driving fpu_done/fpu_result.
module tb_fpu_cpu_bridge;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cpu_cs = 1'b0;
    logic        cpu_wr = 1'b0;
    logic        cpu_rd = 1'b0;
    logic [3:0]  cpu_addr = '0;
    logic [7:0]  cpu_wdata = '0;
    logic [7:0]  cpu_rdata;
    logic        cpu_irq;
    logic        fpu_start;
    logic [3:0]  fpu_op;
    logic [31:0] fpu_a;
    logic [31:0] fpu_b;
    logic [31:0] fpu_result;
    logic        fpu_done;
    logic        fpu_ack;

    always #5 clk = ~clk;

    fpu_cpu_bridge #(.TIMEOUT_CYCLES(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cpu_cs     (cpu_cs),
        .cpu_wr     (cpu_wr),
        .cpu_rd     (cpu_rd),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_irq    (cpu_irq),
        .fpu_start  (fpu_start),
        .fpu_op     (fpu_op),
        .fpu_a      (fpu_a),
        .fpu_b      (fpu_b),
        .fpu_result (fpu_result),
        .fpu_done   (fpu_done),
        .fpu_ack    (fpu_ack)
    );

    int tests = 0;
    int fails = 0;

    logic [7:0] exp_q[$];
    string      nm_q[$];
    logic       rd_seen = 1'b0;

    int   model_lat = 10;
    int   model_hold = 4;
    bit   model_en = 1'b1;
    logic [31:0] model_res = '0;

    int   start_cnt = 0;
    int   irq_cnt = 0;
    int   ack_drop = 0;
    int   cyc = 0;
    int   start_cyc = 0;
    int   irq_cyc = 0;
    bit   ack_watch = 1'b0;
    logic prev_ack = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Read-data scoreboard: one registered byte per cs&rd cycle.
    initial begin
        forever begin
            @(posedge clk);
            rd_seen = cpu_cs && cpu_rd && rst_n;
        end
    end

    initial begin : mon
        logic [7:0] e;
        string      n;
        forever begin
            @(negedge clk);
            if (rd_seen) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_read: got %h expected none",
                             cpu_rdata);
                end else begin
                    e = exp_q.pop_front();
                    n = nm_q.pop_front();
                    if (cpu_rdata !== e) begin
                        fails++;
                        $display("FAIL %s: got %h expected %h",
                                 n, cpu_rdata, e);
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (fpu_start) begin
                start_cnt++;
                start_cyc = cyc;
            end
            if (cpu_irq) begin
                irq_cnt++;
                irq_cyc = cyc;
            end
            if (ack_watch && prev_ack && fpu_done && !fpu_ack)
                ack_drop++;
            prev_ack = fpu_ack;
        end
    end

    // FPU responder: result after model_lat cycles, done held model_hold.
    initial begin
        fpu_done = 1'b0;
        fpu_result = '0;
        forever begin
            @(negedge clk);
            if (fpu_start && model_en && rst_n) begin
                repeat (model_lat) @(negedge clk);
                fpu_result = model_res;
                fpu_done = 1'b1;
                repeat (model_hold) @(negedge clk);
                fpu_done = 1'b0;
            end
        end
    end

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        cpu_cs = 1'b1;
        cpu_wr = 1'b1;
        cpu_addr = a;
        cpu_wdata = d;
        @(negedge clk);
        cpu_cs = 1'b0;
        cpu_wr = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, input logic [7:0] e,
                      input string n);
        @(negedge clk);
        cpu_cs = 1'b1;
        cpu_rd = 1'b1;
        cpu_addr = a;
        exp_q.push_back(e);
        nm_q.push_back(n);
        @(negedge clk);
        cpu_cs = 1'b0;
        cpu_rd = 1'b0;
    endtask

    task automatic wr32(input logic [3:0] base, input logic [31:0] v);
        for (int i = 0; i < 4; i++)
            wr(base + 4'(i), v[8*i +: 8]);
    endtask

    task automatic rd_res(input logic [31:0] v, input string n);
        for (int i = 0; i < 4; i++)
            rd(4'hC + 4'(i), v[8*i +: 8], n);
    endtask

    task automatic wait_irq(input int max, input string n);
        bit got;
        got = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (cpu_irq) begin
                got = 1'b1;
                break;
            end
        end
        tests++;
        if (!got) begin
            fails++;
            $display("FAIL %s: got no irq expected irq within %0d", n, max);
        end
    endtask

    task automatic wait_sig(input bit want_ack, input int max,
                            input string n);
        bit got;
        got = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (want_ack ? fpu_ack : !fpu_done) begin
                got = 1'b1;
                break;
            end
        end
        tests++;
        if (!got) begin
            fails++;
            $display("FAIL %s: got timeout expected event", n);
        end
    endtask

    int s0, i0;

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_rdata", 32'(cpu_rdata), 32'h0);
        chk("rst_irq", 32'(cpu_irq), 32'h0);
        chk("rst_start", 32'(fpu_start), 32'h0);
        chk("rst_ack", 32'(fpu_ack), 32'h0);
        chk("rst_a", fpu_a, 32'h0);
        chk("rst_b", fpu_b, 32'h0);
        chk("rst_op", 32'(fpu_op), 32'h0);
        rst_n = 1'b1;
        rd(4'h9, 8'h00, "rst_status");

        // add 1.0 + 2.0 = 3.0
        wr32(4'h0, 32'h3F800000);
        wr32(4'h4, 32'h40000000);
        chk("add_a", fpu_a, 32'h3F800000);
        chk("add_b", fpu_b, 32'h40000000);
        model_lat = 10;
        model_res = 32'h40400000;
        s0 = start_cnt;
        i0 = irq_cnt;
        ack_watch = 1'b1;
        wr(4'h8, 8'h00);
        rd(4'h9, 8'h01, "add_busy");
        wait_irq(100, "add_irq");
        repeat (3) @(negedge clk);
        ack_watch = 1'b0;
        chk("add_starts", 32'(start_cnt - s0), 32'd1);
        chk("add_irqs", 32'(irq_cnt - i0), 32'd1);
        chk("add_ack_held", 32'(ack_drop), 32'd0);
        rd_res(32'h40400000, "add_res");
        rd(4'h9, 8'h02, "add_status");
        rd(4'h9, 8'h00, "add_status_rc");

        // invalid op
        s0 = start_cnt;
        wr(4'h8, 8'h0F);
        repeat (5) @(negedge clk);
        chk("inv_nostart", 32'(start_cnt - s0), 32'd0);
        rd(4'h9, 8'h08, "inv_status");
        rd(4'h9, 8'h00, "inv_status_rc");

        // operand write while busy
        model_res = 32'h12345678;
        s0 = start_cnt;
        wr(4'h8, 8'h02);
        repeat (3) @(negedge clk);
        wr(4'h0, 8'hAA);
        chk("busy_a", fpu_a, 32'h3F800000);
        wait_irq(100, "busy_irq");
        repeat (2) @(negedge clk);
        chk("busy_starts", 32'(start_cnt - s0), 32'd1);
        rd(4'h9, 8'h0A, "busy_status");
        rd_res(32'h12345678, "busy_res");
        rd(4'hC, 8'h78, "res_persist");
        wr(4'hB, 8'h55);
        rd(4'hB, 8'h00, "undef_addr");
        rd(4'hA, 8'h00, "undef_addr_a");

`ifdef FPU_BRIDGE_TIMEOUT_EN
        model_en = 1'b0;
        i0 = irq_cnt;
        wr(4'h8, 8'h03);
        wait_irq(60, "tmo_irq");
        repeat (2) @(negedge clk);
        chk("tmo_latency", 32'(irq_cyc - start_cyc), 32'd17);
        chk("tmo_irqs", 32'(irq_cnt - i0), 32'd1);
        rd(4'h9, 8'h04, "tmo_status");
        rd(4'hC, 8'h78, "tmo_res_kept");
        model_en = 1'b1;
`else
        model_en = 1'b0;
        i0 = irq_cnt;
        wr(4'h8, 8'h03);
        repeat (2000) @(negedge clk);
        chk("hang_irqs", 32'(irq_cnt - i0), 32'd0);
        rd(4'h9, 8'h01, "hang_status");
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_en = 1'b1;
`endif

        // reset while in the ack state
        model_lat = 2;
        model_hold = 30;
        wr(4'h8, 8'h01);
        wait_sig(1'b1, 30, "rst_reach_ack");
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_ack", 32'(fpu_ack), 32'h0);
        chk("midrst_start", 32'(fpu_start), 32'h0);
        chk("midrst_irq", 32'(cpu_irq), 32'h0);
        rst_n = 1'b1;
        rd(4'h9, 8'h00, "midrst_status");
        wait_sig(1'b0, 60, "midrst_done_low");
        model_hold = 4;
        model_lat = 5;
        model_res = 32'h40800000;
        wr32(4'h0, 32'h40A00000);
        wr32(4'h4, 32'h3F800000);
        chk("sub_a", fpu_a, 32'h40A00000);
        wr(4'h8, 8'h01);
        chk("sub_op", 32'(fpu_op), 32'h1);
        wait_irq(100, "sub_irq");
        rd_res(32'h40800000, "sub_res");
        rd(4'h9, 8'h02, "sub_status");

        repeat (3) @(negedge clk);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
